// File: rtl/bus_xfer_arbiter_if.sv
// Request/grant and decoded bus-select bundle shared by the transfer requesters and the arbiter.
interface bus_xfer_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned NRD  = 19,
    parameter int unsigned NWR  = 20,
    parameter int unsigned IDXW = 5
);
    logic [NREQ-1:0]      req;
    logic [NREQ*IDXW-1:0] req_src;
    logic [NREQ*IDXW-1:0] req_dst;
    logic [NREQ-1:0]      gnt;
    logic [NRD-1:0]       RDec_out;
    logic [NWR-1:0]       WRDec_out;
    logic                 busy;
    logic                 idx_err;

    modport master (
        output req, req_src, req_dst,
        input  gnt, RDec_out, WRDec_out, busy, idx_err
    );

    modport slave (
        input  req, req_src, req_dst,
        output gnt, RDec_out, WRDec_out, busy, idx_err
    );
endinterface

// File: rtl/bus_xfer_arbiter.sv
// Round-robin arbiter for the shared A_BUS: one registered read-select/write-enable pair
// per granted register transfer, back-to-back when several requesters are waiting.
module bus_xfer_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned NRD  = 19,
    parameter int unsigned NWR  = 20,
    parameter int unsigned IDXW = 5
) (
    input  logic               Clock,
    input  logic               Reset_n,
    bus_xfer_arbiter_if.slave  bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, XFER} state_t;

    state_t          state_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [PW-1:0]   w_q;
    logic [NREQ-1:0] gnt_q;
    logic [NRD-1:0]  rdec_q;
    logic [NWR-1:0]  wrdec_q;
    logic            busy_q;
    logic            idx_err_q;

    logic [NREQ-1:0] cand;
    logic [PW-1:0]   nxt_ptr;
    logic [PW-1:0]   start;
    logic [PW-1:0]   win;
    logic            found;
    logic [IDXW-1:0] src_w;
    logic [IDXW-1:0] dst_w;
    logic            err;
    logic [NRD-1:0]  rdec_d;
    logic [NWR-1:0]  wrdec_d;

    assign nxt_ptr = (32'(w_q) == NREQ - 1) ? '0 : w_q + 1'b1;

    // During a transfer the search starts where the pointer is about to move, so
    // back-to-back grants rotate exactly as if the pointer had already advanced.
    always_comb begin
        cand  = (state_q == XFER) ? (bus.req & ~gnt_q) : bus.req;
        start = (state_q == XFER) ? nxt_ptr : rr_ptr_q;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && cand[(32'(start) + k) % NREQ]) begin
                found = 1'b1;
                win   = PW'((32'(start) + k) % NREQ);
            end
        end
        src_w   = bus.req_src[32'(win)*IDXW +: IDXW];
        dst_w   = bus.req_dst[32'(win)*IDXW +: IDXW];
        err     = (32'(src_w) >= NRD) || (32'(dst_w) >= NWR);
        rdec_d  = '0;
        wrdec_d = '0;
        if (found && !err) begin
            rdec_d  = NRD'(1) << src_w;
            wrdec_d = NWR'(1) << dst_w;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            w_q       <= '0;
            gnt_q     <= '0;
            rdec_q    <= '0;
            wrdec_q   <= '0;
            busy_q    <= 1'b0;
            idx_err_q <= 1'b0;
        end else begin
            case (state_q)
                XFER:    rr_ptr_q <= nxt_ptr;
                default: rr_ptr_q <= rr_ptr_q;
            endcase
            if (found) begin
                state_q   <= XFER;
                w_q       <= win;
                gnt_q     <= NREQ'(1) << win;
                rdec_q    <= rdec_d;
                wrdec_q   <= wrdec_d;
                busy_q    <= 1'b1;
                idx_err_q <= err;
            end else begin
                state_q   <= IDLE;
                gnt_q     <= '0;
                rdec_q    <= '0;
                wrdec_q   <= '0;
                busy_q    <= 1'b0;
                idx_err_q <= 1'b0;
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.RDec_out  = rdec_q;
    assign bus.WRDec_out = wrdec_q;
    assign bus.busy      = busy_q;
    assign bus.idx_err   = idx_err_q;
endmodule

// File: doc/bus_xfer_arbiter.md
Name: bus_xfer_arbiter

Overview:
- Shares the single A_BUS between several register-transfer requesters, e.g. the control-unit microsequencer, the interrupt/PC-save logic and a debug port.
- Each request names a source register (read-decoder index) and a destination register (write-decoder index).
- The block arbitrates round-robin and drives registered one-hot RDec_out/WRDec_out for exactly one cycle per granted transfer. The selected register drives A_BUS and the destination (e.g. AR) latches it at the end of that cycle.

Parameters:
- NREQ, 4, number of requesters.
- NRD, 19, width of the one-hot read-select vector (RDec_out).
- NWR, 20, width of the one-hot write-enable vector (WRDec_out).
- IDXW, 5, width of each source/destination index.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester transfer request, level.
- req_src  in  NREQ*IDXW  packed source indices; requester i uses bits [i*IDXW +: IDXW].
- req_dst  in  NREQ*IDXW  packed destination indices, same packing as req_src.
- gnt  out  NREQ  one-hot grant; high only during the transfer cycle of the winner.
- RDec_out  out  NRD  one-hot bus-source select; registered.
- WRDec_out  out  NWR  one-hot register write enable; registered.
- busy  out  1  high in XFER.
- idx_err  out  1  one-cycle pulse when the granted request carries an out-of-range index.

Behaviour:
- Reset (Reset_n=0, asynchronous): state=IDLE, rr_ptr=0, and gnt, RDec_out, WRDec_out, busy and idx_err all 0, immediately and regardless of Clock. A transfer in progress is dropped with no write. Release is synchronous to the next rising edge.
- States: IDLE and XFER.
- Arbitration (combinational on the current inputs):
  - Candidates are req masked as described below.
  - Winner w is the first set bit searching from rr_ptr upward, wrapping from NREQ-1 to 0.
- IDLE:
  - No candidate: stay in IDLE; all outputs 0.
  - Candidate exists: at the clock edge, register w, decode req_src[w] into RDec_out and req_dst[w] into WRDec_out, set gnt[w]=1 and busy=1, and go to XFER.
  - Latency from req rising to RDec/WRDec/gnt high is 1 cycle.
- XFER (outputs held exactly one cycle):
  - At the edge, rr_ptr <= (w+1) mod NREQ.
  - The candidate mask excludes the current winner w, so the winner's still-high req is not re-granted.
  - Another candidate exists: load the next winner and stay in XFER (back-to-back, one transfer per cycle).
  - No other candidate: go to IDLE and clear all outputs.
- Requester rule: hold req, src and dst stable until gnt is seen, then drop req on the following cycle. If req is still high one cycle after the grant, it is a new request and takes its round-robin turn.
- Index range check:
  - src >= NRD or dst >= NWR marks the transfer as an error.
  - The grant is still issued and the pointer still advances.
  - RDec_out=0 and WRDec_out=0 for that cycle; no partial transfer (if only dst is bad, RDec is also suppressed).
  - idx_err=1 for the same cycle.
- src==dst is legal: both bits are set, and the register reloads its own value.
- Exactly one bit may be set in each of RDec_out and WRDec_out; the bench asserts this every cycle.
- A requester that drops req before its grant is withdrawn; no grant is issued to it.
- Indices are sampled only at the decision edge; later changes have no effect on the issued transfer.

Test Plan:
- Reset mid-transfer: assert Reset_n=0 while in XFER -> RDec_out, WRDec_out and gnt read 0 within the same cycle with no Clock edge; after release, rr_ptr=0.
- Single request: req=0001, src=1, dst=2 -> one cycle later RDec_out=19'h00002, WRDec_out=20'h00004, gnt=0001 for exactly 1 cycle, then IDLE and all outputs 0. Bus value 16'h5555 is latched in the destination register.
- Round-robin: all four requesters hold req, each dropping 1 cycle after its grant -> grants in order 0001, 0010, 0100, 1000 on consecutive cycles with busy continuously high. A repeat with rr_ptr=2 grants in order 2, 3, 0, 1.
- Fairness under persistent requests: req[0] and req[1] never drop -> grants alternate 0, 1, 0, 1 and neither is starved.
- Range error: src=19 or dst=25 -> gnt pulses, idx_err=1, and RDec_out=WRDec_out=0 for that cycle; the next request proceeds normally.
- Index stability: change req_dst during the XFER cycle -> WRDec_out keeps the value sampled at the decision edge.
